// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared frame-buffer constants, arbiter FSM states and
//               grant-source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;
    localparam int FB_SIZE   = 130560;

    typedef logic [0:0] fb_state_t;
    localparam fb_state_t IDLE  = 1'b0;
    localparam fb_state_t CLEAR = 1'b1;

    typedef logic [1:0] fb_grant_t;
    localparam fb_grant_t G_NONE = 2'd0;
    localparam fb_grant_t G_SCAN = 2'd1;
    localparam fb_grant_t G_CLR  = 2'd2;
    localparam fb_grant_t G_WR   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_wr_fifo
// Description : Synchronous FIFO holding queued {addr,data} pixel writes.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w:0]  r_wr_ptr;
    logic [c_ptr_w:0]  r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    // Extra pointer MSB distinguishes a full queue from an empty one.
    assign full   = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                    (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rest) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Single-port frame-buffer arbiter: scan-out reads, queued pixel
//               writes and a full-screen clear engine. Optional FB_ARB_STATS_EN
//               adds a write-stall counter port (stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
    parameter int DATA_W     = fb_pkg::FB_DATA_W,
    parameter int FB_SIZE    = fb_pkg::FB_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              scan_de,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    import fb_pkg::*;

    localparam logic [ADDR_W:0]   c_fb_size   = (ADDR_W+1)'(FB_SIZE);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_SIZE - 1);

    fb_state_t            r_state;
    logic [ADDR_W-1:0]    r_clr_cnt;
    logic [DATA_W-1:0]    r_clr_color;
    logic                 r_clr_done;
    logic                 r_clr_busy;
    logic                 r_rd1;
    logic                 r_rd2;
    logic [ADDR_W-1:0]    r_ram_addr;
    logic                 r_ram_we;
    logic [DATA_W-1:0]    r_ram_wdata;

    fb_grant_t                w_grant;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_full;
    logic                     w_empty;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]        w_head_addr;
    logic [DATA_W-1:0]        w_head_data;
    logic                     w_head_valid;

    assign wr_ready     = !w_full && !rest;
    assign w_push       = wr_req && wr_ready;
    assign w_head_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign w_head_data  = w_head[DATA_W-1:0];
    assign w_head_valid = ({1'b0, w_head_addr} < c_fb_size);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rest      (rest),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({wr_addr, wr_data}),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Scan-out first so the panel never starves; writes only use blanking.
    always_comb begin
        w_grant = G_NONE;
        w_pop   = 1'b0;
        if (scan_de) begin
            w_grant = G_SCAN;
        end else if (r_state == CLEAR) begin
            w_grant = G_CLR;
        end else if (!w_empty) begin
            w_grant = G_WR;
            w_pop   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state     <= IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            r_clr_done  <= 1'b0;
            r_clr_busy  <= 1'b0;
            r_rd1       <= 1'b0;
            r_rd2       <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_rd1      <= (w_grant == G_SCAN);
            r_rd2      <= r_rd1;
            r_clr_done <= 1'b0;
            // Busy tracks the registered RAM side, so it brackets the clear writes.
            r_clr_busy <= (r_state == CLEAR);

            case (w_grant)
                G_SCAN: begin
                    r_ram_addr  <= scan_addr;
                    r_ram_we    <= 1'b0;
                    r_ram_wdata <= '0;
                end
                G_CLR: begin
                    r_ram_addr  <= r_clr_cnt;
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= r_clr_color;
                end
                G_WR: begin
                    r_ram_addr  <= w_head_addr;
                    r_ram_we    <= w_head_valid;
                    r_ram_wdata <= w_head_data;
                end
                default: begin
                    r_ram_we    <= 1'b0;
                    r_ram_wdata <= '0;
                end
            endcase

            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_state     <= CLEAR;
                        r_clr_cnt   <= '0;
                        r_clr_color <= clr_color;
                    end
                end
                CLEAR: begin
                    if (w_grant == G_CLR) begin
                        if (r_clr_cnt == c_last_addr) begin
                            r_state    <= IDLE;
                            r_clr_done <= 1'b1;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign scan_valid = r_rd2;
    assign scan_data  = r_rd2 ? ram_rdata : '0;
    assign clr_busy   = r_clr_busy;
    assign clr_done   = r_clr_done;

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rest) begin
            r_stall_cnt <= '0;
        end else if (wr_req && !wr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_port_arbiter
// Description : Directed self-checking bench for fb_port_arbiter with a
//               synchronous-read RAM model; reduced frame size keeps clears short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int c_size = 1200;

    logic        clk = 1'b0;
    logic        rest;
    logic        scan_de;
    logic [16:0] scan_addr;
    logic [15:0] scan_data;
    logic        scan_valid;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clr_start;
    logic [15:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    logic [15:0] mem [c_size];
    logic [16:0] log_addr [$];
    logic [15:0] log_data [$];
    logic        logging = 1'b0;
    int          done_cnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    fb_port_arbiter #(
        .ADDR_W     (17),
        .DATA_W     (16),
        .FB_SIZE    (c_size),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rest       (rest),
        .scan_de    (scan_de),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef FB_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < c_size; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[5] = 16'h1234;
    end

    always @(posedge clk) begin
        if (ram_addr < 17'(c_size)) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end else begin
            ram_rdata <= '0;
        end
    end

    always @(negedge clk) begin
        if (logging && ram_we) begin
            log_addr.push_back(ram_addr);
            log_data.push_back(ram_wdata);
        end
        if (logging && clr_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int we_cnt;
        int bad;

        rest = 1'b1; scan_de = 1'b0; scan_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_color = '0;
        repeat (3) tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_scan_valid", 32'(scan_valid), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        rest = 1'b0;
        tick();
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Scan read: data appears two cycles after the request.
        scan_de = 1'b1; scan_addr = 17'd5;
        tick();
        scan_de = 1'b0;
        chk("scan_ram_addr", 32'(ram_addr), 32'd5);
        chk("scan_no_we", 32'(ram_we), 32'd0);
        chk("scan_valid_early", 32'(scan_valid), 32'd0);
        tick();
        chk("scan_valid", 32'(scan_valid), 32'd1);
        chk("scan_data", 32'(scan_data), 32'h1234);
        tick();
        chk("scan_valid_drop", 32'(scan_valid), 32'd0);

        // Single queued write lands two cycles after the push.
        wr_req = 1'b1; wr_addr = 17'd100; wr_data = 16'hF800;
        tick();
        wr_req = 1'b0;
        chk("wr_lat1_we", 32'(ram_we), 32'd0);
        tick();
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'd100);
        chk("wr_wdata", 32'(ram_wdata), 32'hF800);
        tick();
        chk("wr_we_drop", 32'(ram_we), 32'd0);
        chk("wr_mem100", 32'(mem[100]), 32'hF800);

        // Active scan blocks writes; queue fills after four pushes.
        we_cnt = 0;
        for (int c = 0; c < 480; c++) begin
            scan_de = 1'b1; scan_addr = 17'(c);
            wr_req = (c < 5);
            wr_addr = 17'(200 + c); wr_data = 16'hA000 + 16'(c);
            if (c == 4) chk("fifo_full_ready", 32'(wr_ready), 32'd0);
            tick();
            if (ram_we) we_cnt++;
        end
        chk("scan_blocks_we", 32'(we_cnt), 32'd0);
        chk("still_full", 32'(wr_ready), 32'd0);
        scan_de = 1'b0; wr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_we", 32'(ram_we), 32'd1);
            chk("drain_addr", 32'(ram_addr), 32'(200 + k));
            chk("drain_data", 32'(ram_wdata), 32'hA000 + 32'(k));
        end
        tick();
        chk("drain_fifth_absent", 32'(ram_we), 32'd0);
        chk("drain_ready", 32'(wr_ready), 32'd1);

        // Full clear with a write queued mid-clear and an ignored restart.
        log_addr.delete(); log_data.delete(); done_cnt = 0; logging = 1'b1;
        clr_color = 16'h0000; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 0; c < 1250; c++) begin
            wr_req = (c == 10); wr_addr = 17'd7; wr_data = 16'h7777;
            clr_start = (c == 20);
            if (c >= 20) clr_color = 16'hFFFF;
            if (c == 500) chk("clr_busy_mid", 32'(clr_busy), 32'd1);
            tick();
        end
        logging = 1'b0; clr_color = '0;
        chk("clr_log_len", 32'(log_addr.size()), 32'(c_size + 1));
        bad = 0;
        if (log_addr.size() == c_size + 1) begin
            for (int i = 0; i < c_size; i++)
                if (log_addr[i] !== 17'(i) || log_data[i] !== 16'h0000) bad++;
            chk("clr_seq_errors", 32'(bad), 32'd0);
            chk("clr_then_wr_addr", 32'(log_addr[c_size]), 32'd7);
            chk("clr_then_wr_data", 32'(log_data[c_size]), 32'h7777);
        end
        chk("clr_done_count", 32'(done_cnt), 32'd1);
        chk("clr_busy_end", 32'(clr_busy), 32'd0);
        chk("clr_mem7", 32'(mem[7]), 32'h7777);
        chk("clr_mem5", 32'(mem[5]), 32'h0000);
        chk("clr_mem_last", 32'(mem[c_size-1]), 32'h0000);

        // Reset in the middle of a clear squashes it and the queued write.
        clr_color = 16'h00FF; clr_start = 1'b1;
        tick();
        clr_start = 1'b0; clr_color = '0;
        for (int k = 0; k < 1000; k++) begin
            wr_req = (k == 5); wr_addr = 17'd50; wr_data = 16'h5555;
            tick();
        end
        wr_req = 1'b0;
        rest = 1'b1;
        tick();
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_ready", 32'(wr_ready), 32'd0);
        chk("abort_done", 32'(clr_done), 32'd0);
        rest = 1'b0;
        #1;
        chk("abort_ready_rel", 32'(wr_ready), 32'd1);
        we_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ram_we) we_cnt++;
        end
        chk("abort_no_stale", 32'(we_cnt), 32'd0);
        chk("abort_mem50", 32'(mem[50]), 32'h00FF);
        chk("abort_mem999", 32'(mem[999]), 32'h00FF);
        chk("abort_mem1000", 32'(mem[1000]), 32'h0000);

        // Out-of-range write is consumed without a RAM write.
        wr_req = 1'b1; wr_addr = 17'(c_size); wr_data = 16'h1111;
        tick();
        wr_req = 1'b0;
        tick();
        chk("oob_no_we", 32'(ram_we), 32'd0);
        tick();
        chk("oob_no_we2", 32'(ram_we), 32'd0);
        wr_req = 1'b1; wr_addr = 17'd300; wr_data = 16'h3333;
        tick();
        wr_req = 1'b0;
        tick();
        chk("after_oob_we", 32'(ram_we), 32'd1);
        chk("after_oob_addr", 32'(ram_addr), 32'd300);
        tick();

`ifdef FB_ARB_STATS_EN
        chk("stall_start", 32'(stall_cnt), 32'd0);
        scan_de = 1'b1; scan_addr = '0;
        for (int k = 0; k < 14; k++) begin
            wr_req = 1'b1; wr_addr = 17'(400 + k); wr_data = 16'(k);
            tick();
        end
        wr_req = 1'b0;
        chk("stall_cnt", 32'(stall_cnt), 32'd10);
        scan_de = 1'b0;
        repeat (6) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
